mult_stage: RTL and testbench
=============================

MULT_STAGE -- requirements
Module: mult_stage

Interface
REQ-001 The block SHALL have parameter MREG, default 1, which sets the multiplier output pipeline stages; legal values are 0 or 1.
REQ-002 The block SHALL have parameter USE_MULT, default "MULTIPLY", which selects multiplier use; legal values are "MULTIPLY" or "NONE".
REQ-003 The block SHALL have port clk: input, 1 bit, single clock, all state updates on rising edge.
REQ-004 The block SHALL have port RSTM: input, 1 bit, reset for the M register; synchronous, active-high.
REQ-005 The block SHALL have port CEM: input, 1 bit, clock enable for the M register.
REQ-006 The block SHALL have port AMULT: input, 25 bits, signed multiplicand from the A/AD register stage.
REQ-007 The block SHALL have port BMULT: input, 18 bits, signed multiplier from the dual B register stage.
REQ-008 The block SHALL have port MX: output, 43 bits, signed partial product 0, feeding the X mux.
REQ-009 The block SHALL have port MY: output, 43 bits, signed partial product 1, feeding the Y mux.

Function
REQ-010 The block SHALL split BMULT into BL = BMULT[8:0], treated as unsigned, and BH = BMULT[17:9], treated as signed 9-bit.
REQ-011 The block SHALL compute PX = AMULT (signed) x {1'b0,BL}, sign-extended to 43 bits.
REQ-012 The block SHALL compute PY = (AMULT (signed) x BH (signed)) shifted left by 9, taken as 43 bits.
REQ-013 PX+PY, modulo 2^43, SHALL equal the exact signed product AMULT x BMULT for every input pair.
REQ-014 The 43-bit addition of PX and PY SHALL never overflow, including when AMULT = -2^24 and BMULT = -2^17.
REQ-015 With MREG=1, MX and MY SHALL be registered copies of PX and PY, with 1-cycle latency from the inputs.
REQ-016 With MREG=1, the M register SHALL load PX and PY on a clk rising edge when CEM=1 and RSTM=0.
REQ-017 With MREG=1 and CEM=0, MX and MY SHALL hold their values regardless of any input changes.
REQ-018 With MREG=0, MX and MY SHALL equal PX and PY combinationally, with zero latency.
REQ-019 With MREG=0, CEM and RSTM SHALL have no effect.
REQ-020 With USE_MULT="NONE", MX and MY SHALL be constant 0 and no M register SHALL be inferred.
REQ-021 BMULT SHALL be consumed as delivered by the B register stage; the block SHALL add no extra B delay.
REQ-022 An elaboration-time error SHALL be raised for an illegal MREG or USE_MULT value.

Reset
REQ-023 With MREG=1, when RSTM=1 on a rising edge, MX and MY SHALL be 0 after that edge.
REQ-024 RSTM SHALL take priority over CEM, so reset clears the register even when CEM=0.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight product; the next load SHALL occur at the first edge where RSTM=0 and CEM=1.
REQ-026 There SHALL be no asynchronous reset path, so MX and MY SHALL not change between clock edges when MREG=1.

Verification
REQ-027 Scenario (MREG=1, reset): hold RSTM=1 for 2 edges with AMULT=100 and BMULT=7; MX and MY SHALL be 0. Then set RSTM=0, CEM=1; after 1 edge MX=700 and MY=0.
REQ-028 Scenario (signed mix): set AMULT=-1 and BMULT=18'h1FFFF. One edge later, MX SHALL be -511, MY SHALL be -130560, and MX+MY SHALL be -131071.
REQ-029 Scenario (corner): set AMULT=-2^24 and BMULT=-2^17. Then MX SHALL be 0 and MY SHALL be 2^41, which is positive with no wrap.
REQ-030 Scenario (enable hold): load AMULT=3 and BMULT=5, giving MX=15. Set CEM=0 and change the inputs to 9 and 9 for 3 edges; MX SHALL stay 15. Then pulse RSTM=1 with CEM=0; MX SHALL become 0.
REQ-031 Scenario (MREG=0): with AMULT=1000 and BMULT=-600, MX+MY SHALL be -600000 in the same cycle. Toggling RSTM and CEM SHALL have no effect.
REQ-032 Scenario (random): 10000 random input pairs at MREG=1 and CEM=1. On every edge, MX+MY SHALL equal the product of the inputs from 1 cycle earlier.
REQ-033 Scenario (USE_MULT): with USE_MULT="NONE", MX and MY SHALL be 0 for all inputs.

Source files
------------

// File: rtl/mult_stage.sv
// mult_stage: 25x18 signed multiplier split into two 43-bit partial products with an optional M register.
module mult_stage #(
    parameter int    MREG     = 1,
    parameter string USE_MULT = "MULTIPLY"
) (
    input  logic               clk,
    input  logic               RSTM,
    input  logic               CEM,
    input  logic signed [24:0] AMULT,
    input  logic signed [17:0] BMULT,
    output logic signed [42:0] MX,
    output logic signed [42:0] MY
);
    if (MREG != 0 && MREG != 1) begin : g_bad_mreg
        $error("mult_stage: MREG must be 0 or 1");
    end
    if (USE_MULT != "MULTIPLY" && USE_MULT != "NONE") begin : g_bad_use
        $error("mult_stage: USE_MULT must be MULTIPLY or NONE");
    end
    if (USE_MULT == "NONE") begin : g_none
        assign MX = '0;
        assign MY = '0;
    end else begin : g_mult
        logic signed [42:0] a, bl, bh, px, py;
        assign a  = 43'(AMULT);
        assign bl = 43'($signed({1'b0, BMULT[8:0]}));
        assign bh = 43'($signed(BMULT[17:9]));
        // Low half is unsigned, high half carries the sign; |a*bh| <= 2^32 so the shift never wraps.
        assign px = a * bl;
        assign py = (a * bh) <<< 9;
        if (MREG == 1) begin : g_reg
            always_ff @(posedge clk) begin
                if (RSTM) begin
                    MX <= '0;
                    MY <= '0;
                end else if (CEM) begin
                    MX <= px;
                    MY <= py;
                end
            end
        end else begin : g_comb
            assign MX = px;
            assign MY = py;
        end
    end
endmodule

// File: tb/tb_mult_stage.sv
// tb_mult_stage: directed table, corner sequences and random checks for mult_stage in all three configurations.
module tb_mult_stage;
    logic clk = 0;
    logic rstm, cem;
    logic signed [24:0] a;
    logic signed [17:0] b;
    logic signed [42:0] m1_mx, m1_my, m0_mx, m0_my, n_mx, n_my;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mult_stage #(.MREG(1), .USE_MULT("MULTIPLY")) u_m1 (
        .clk(clk), .RSTM(rstm), .CEM(cem), .AMULT(a), .BMULT(b), .MX(m1_mx), .MY(m1_my)
    );
    mult_stage #(.MREG(0), .USE_MULT("MULTIPLY")) u_m0 (
        .clk(clk), .RSTM(rstm), .CEM(cem), .AMULT(a), .BMULT(b), .MX(m0_mx), .MY(m0_my)
    );
    mult_stage #(.MREG(1), .USE_MULT("NONE")) u_none (
        .clk(clk), .RSTM(rstm), .CEM(cem), .AMULT(a), .BMULT(b), .MX(n_mx), .MY(n_my)
    );

    typedef struct {
        logic signed [24:0] a;
        logic signed [17:0] b;
        logic signed [42:0] mx;
        logic signed [42:0] my;
    } vec_t;

    task automatic chk(input string name, input logic signed [42:0] act, input logic signed [42:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vec[8];
        logic signed [42:0] exp_sum;
        vec[0] = '{25'sd100, 18'sd7, 43'sd700, 43'sd0};
        vec[1] = '{-25'sd1, 18'h1FFFF, -43'sd511, -43'sd130560};
        vec[2] = '{25'h1000000, 18'h20000, 43'sd0, 43'sd2199023255552};
        vec[3] = '{25'sd3, 18'sd5, 43'sd15, 43'sd0};
        vec[4] = '{25'sd1000, -18'sd600, 43'sd424000, -43'sd1024000};
        vec[5] = '{25'sd16777215, 18'sd131071, 43'sd8573156865, 43'sd2190433190400};
        vec[6] = '{25'sd0, 18'sd0, 43'sd0, 43'sd0};
        vec[7] = '{-25'sd5, 18'sd1, -43'sd5, 43'sd0};

        // Reset scenario: two reset edges, then a load.
        rstm = 1; cem = 1; a = 25'sd100; b = 18'sd7;
        tick();
        tick();
        chk("rst_mx", m1_mx, 43'sd0);
        chk("rst_my", m1_my, 43'sd0);
        chk("none_rst_mx", n_mx, 43'sd0);
        rstm = 0;
        tick();
        chk("rst_load_mx", m1_mx, 43'sd700);
        chk("rst_load_my", m1_my, 43'sd0);

        // Directed table: combinational path checked before the edge, register after.
        for (int i = 0; i < 8; i++) begin
            a = vec[i].a; b = vec[i].b;
            #1;
            chk($sformatf("m0_mx[%0d]", i), m0_mx, vec[i].mx);
            chk($sformatf("m0_my[%0d]", i), m0_my, vec[i].my);
            tick();
            chk($sformatf("m1_mx[%0d]", i), m1_mx, vec[i].mx);
            chk($sformatf("m1_my[%0d]", i), m1_my, vec[i].my);
            chk($sformatf("m1_sum[%0d]", i), m1_mx + m1_my, 43'(vec[i].a) * 43'(vec[i].b));
            chk($sformatf("none_mx[%0d]", i), n_mx, 43'sd0);
            chk($sformatf("none_my[%0d]", i), n_my, 43'sd0);
        end

        // Enable hold, then reset overriding CEM=0.
        a = 25'sd3; b = 18'sd5;
        tick();
        chk("hold_load", m1_mx, 43'sd15);
        cem = 0; a = 25'sd9; b = 18'sd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_edge", m1_mx, 43'sd15);
            #3;
            chk("hold_mid", m1_mx, 43'sd15);
        end
        rstm = 1;
        tick();
        chk("hold_rst_mx", m1_mx, 43'sd0);
        chk("hold_rst_my", m1_my, 43'sd0);

        // Reset mid-operation drops the product; next load waits for CEM=1.
        rstm = 1; cem = 1; a = 25'sd7; b = 18'sd11;
        tick();
        chk("mid_rst", m1_mx, 43'sd0);
        rstm = 0; cem = 0;
        tick();
        chk("mid_noce", m1_mx, 43'sd0);
        cem = 1;
        tick();
        chk("mid_load", m1_mx, 43'sd77);

        // MREG=0 ignores RSTM and CEM.
        a = 25'sd1000; b = -18'sd600;
        #1;
        chk("m0_sum", m0_mx + m0_my, -43'sd600000);
        for (int i = 0; i < 4; i++) begin
            rstm = i[0]; cem = i[1];
            tick();
            chk("m0_toggle", m0_mx + m0_my, -43'sd600000);
        end
        rstm = 0; cem = 1;
        tick();

        // Random: registered sum equals the previous cycle's full product.
        exp_sum = 43'(a) * 43'(b);
        for (int i = 0; i < 10000; i++) begin
            a = 25'($urandom);
            b = 18'($urandom);
            #1;
            chk("rnd_m0", m0_mx + m0_my, 43'(a) * 43'(b));
            chk("rnd_none", n_mx | n_my, 43'sd0);
            tick();
            chk("rnd_m1", m1_mx + m1_my, 43'(a) * 43'(b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
